// File: rtl/neopixel_rx_pkg.sv
// Shared types and default timing for the NeoPixel receiver.
package neopixel_rx_pkg;

    localparam int unsigned CNT_W     = 12;
    localparam int unsigned WORD_W    = 24;
    localparam int unsigned BIT_CNT_W = 5;

    localparam int unsigned DEF_CLK_HZ    = 50_000_000;
    localparam int unsigned DEF_MIN_HIGH  = 6;
    localparam int unsigned DEF_THRESH_1  = 26;
    localparam int unsigned DEF_MAX_HIGH  = 60;
    localparam int unsigned DEF_LATCH_LOW = 2000;

    typedef enum logic [1:0] {
        RESYNC  = 2'd0,
        CAPTURE = 2'd1,
        HIGH    = 2'd2,
        FORWARD = 2'd3
    } state_t;

endpackage

// File: rtl/neopixel_rx_pulse_timer.sv
// Saturating up-counter; clear with enable restarts the count at 1.
module pulse_timer
    import neopixel_rx_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] SAT = '1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= enable ? W'(1) : '0;
        end else if (enable && count != SAT) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/neopixel_rx.sv
// NeoPixel receiver: decodes the first 24-bit pixel word of a frame, then
// forwards the rest of the frame downstream until the latch gap.
module neopixel_rx
    import neopixel_rx_pkg::*;
#(
    parameter int unsigned CLK_HZ    = DEF_CLK_HZ,
    parameter int unsigned MIN_HIGH  = DEF_MIN_HIGH,
    parameter int unsigned THRESH_1  = DEF_THRESH_1,
    parameter int unsigned MAX_HIGH  = DEF_MAX_HIGH,
    parameter int unsigned LATCH_LOW = DEF_LATCH_LOW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              din,
    output logic              dout,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_done,
    output logic              bit_error,
    output logic              armed
);

    localparam logic [CNT_W-1:0]     MIN_C    = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0]     THR_C    = CNT_W'(THRESH_1);
    localparam logic [CNT_W-1:0]     OVF_C    = CNT_W'(MAX_HIGH + 1);
    localparam logic [CNT_W-1:0]     LATCH_C  = CNT_W'(LATCH_LOW);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WORD_W - 1);
    localparam logic [BIT_CNT_W-1:0] N_BITS   = BIT_CNT_W'(WORD_W);

    // Timing constants must be ordered and fit the 12-bit counters.
    if (CLK_HZ == 0 || MIN_HIGH == 0 || MIN_HIGH >= THRESH_1 || THRESH_1 > MAX_HIGH ||
        MAX_HIGH + 1 >= LATCH_LOW || LATCH_LOW > (1 << CNT_W) - 1) begin : g_bad_params
        $error("neopixel_rx: inconsistent timing parameters");
    end

    logic din_m, din_s, din_q;
    logic rise, fall;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            din_m <= 1'b0;
            din_s <= 1'b0;
            din_q <= 1'b0;
        end else begin
            din_m <= din;
            din_s <= din_m;
            din_q <= din_s;
        end
    end

    assign rise = din_s & ~din_q;
    assign fall = ~din_s & din_q;

    logic             low_clr, low_en, high_clr, high_en;
    logic [CNT_W-1:0] low_cnt, high_cnt;

    pulse_timer #(.W(CNT_W)) u_low_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (low_clr),
        .enable (low_en),
        .count  (low_cnt)
    );

    pulse_timer #(.W(CNT_W)) u_high_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (high_clr),
        .enable (high_en),
        .count  (high_cnt)
    );

    state_t                state, state_n;
    logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [WORD_W-2:0]     shift, shift_n;
    logic [WORD_W-1:0]     rx_data_n;
    logic                  rx_valid_n, frame_done_n, bit_error_n, armed_n;
    logic                  take_rise, latch, bit_val;

    assign latch   = (low_cnt >= LATCH_C);
    assign bit_val = (high_cnt >= THR_C);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= RESYNC;
            bit_cnt    <= '0;
            shift      <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_done <= 1'b0;
            bit_error  <= 1'b0;
            armed      <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            rx_data    <= rx_data_n;
            rx_valid   <= rx_valid_n;
            frame_done <= frame_done_n;
            bit_error  <= bit_error_n;
            armed      <= armed_n;
        end
    end

    // Latch handling happens first in each state; a coincident rise is taken afterwards.
    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        rx_data_n    = rx_data;
        rx_valid_n   = 1'b0;
        frame_done_n = 1'b0;
        bit_error_n  = 1'b0;
        low_clr      = din_s;
        low_en       = ~din_s;
        high_clr     = 1'b0;
        high_en      = 1'b0;
        take_rise    = 1'b0;

        unique case (state)
            RESYNC: begin
                if (latch) begin
                    state_n   = CAPTURE;
                    bit_cnt_n = '0;
                    take_rise = rise;
                end
            end
            CAPTURE: begin
                if (latch && bit_cnt != '0) begin
                    bit_error_n  = 1'b1;
                    frame_done_n = 1'b1;
                    bit_cnt_n    = '0;
                end
                take_rise = rise;
            end
            HIGH: begin
                low_clr = 1'b1;
                low_en  = 1'b0;
                high_en = din_s;
                if (high_cnt >= OVF_C) begin
                    bit_error_n = 1'b1;
                    state_n     = RESYNC;
                end else if (fall) begin
                    if (high_cnt < MIN_C) begin
                        bit_error_n = 1'b1;
                        state_n     = RESYNC;
                    end else begin
                        shift_n   = {shift[WORD_W-3:0], bit_val};
                        bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            rx_data_n  = {shift, bit_val};
                            rx_valid_n = 1'b1;
                            state_n    = FORWARD;
                        end else begin
                            state_n = CAPTURE;
                        end
                    end
                end
            end
            FORWARD: begin
                if (latch) begin
                    frame_done_n = 1'b1;
                    bit_cnt_n    = '0;
                    state_n      = CAPTURE;
                    take_rise    = rise;
                end
            end
        endcase

        if (take_rise) begin
            state_n  = HIGH;
            high_clr = 1'b1;
            high_en  = 1'b1;
        end

        armed_n = (state_n == CAPTURE || state_n == HIGH) && (bit_cnt_n < N_BITS);
    end

    assign dout = (state == FORWARD) & din_s;

endmodule

// File: tb/tb_neopixel_rx.sv
// Directed bench for neopixel_rx: decode, forward, latch, error and reset scenarios.
module tb_neopixel_rx;

    logic        clock = 1'b0;
    logic        reset;
    logic        din;
    logic        dout;
    logic [23:0] rx_data;
    logic        rx_valid, frame_done, bit_error, armed;

    int vectors     = 0;
    int miscompares = 0;

    int   n_valid = 0, n_frame = 0, n_err = 0, n_both = 0, n_dbl = 0;
    int   dout_ones = 0, dout_bad = 0;
    logic fwd_check = 1'b0;
    logic din_h1 = 1'b0, din_h2 = 1'b0;
    logic pv = 1'b0, pf = 1'b0, pe = 1'b0;

    always #5 clock = ~clock;

    neopixel_rx dut (
        .clock      (clock),
        .reset      (reset),
        .din        (din),
        .dout       (dout),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_done (frame_done),
        .bit_error  (bit_error),
        .armed      (armed)
    );

    // Pulse counters and a 2-cycle-delayed reference for forwarded data.
    always @(negedge clock) begin
        if (fwd_check && dout !== din_h2) dout_bad++;
        din_h2 = din_h1;
        din_h1 = din;
        if (!reset) begin
            if (rx_valid) n_valid++;
            if (frame_done) n_frame++;
            if (bit_error) n_err++;
            if (frame_done && bit_error) n_both++;
            if ((rx_valid && pv) || (frame_done && pf) || (bit_error && pe)) n_dbl++;
        end
        pv = rx_valid;
        pf = frame_done;
        pe = bit_error;
        if (dout) dout_ones++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        din = v;
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic send_bits(input logic [23:0] w, input int nbits);
        for (int i = 23; i > 23 - nbits; i--) begin
            if (w[i]) begin
                drive(1'b1, 35);
                drive(1'b0, 30);
            end else begin
                drive(1'b1, 18);
                drive(1'b0, 40);
            end
        end
    endtask

    task automatic send_word(input logic [23:0] w);
        send_bits(w, 24);
    endtask

    initial begin
        int d0, f0, e0, b0, v0;
        reset = 1'b1;
        din   = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        check("rst_rx_data",    32'(rx_data),    32'h0);
        check("rst_rx_valid",   32'(rx_valid),   32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        check("rst_bit_error",  32'(bit_error),  32'h0);
        check("rst_armed",      32'(armed),      32'h0);
        check("rst_dout",       32'(dout),       32'h0);

        reset = 1'b0;
        drive(1'b0, 2050);
        check("gap_armed",       32'(armed), 32'h1);
        check("resync_no_frame", n_frame,    0);

        d0 = dout_ones;
        send_word(24'hA5C3F0);
        check("w1_valid_count", n_valid,          1);
        check("w1_data",        32'(rx_data),     32'h00A5C3F0);
        check("w1_armed",       32'(armed),       32'h0);
        check("w1_dout_quiet",  dout_ones - d0,   0);
        check("w1_no_err",      n_err,            0);

        fwd_check = 1'b1;
        d0 = dout_ones;
        send_word(24'h00FF00);
        fwd_check = 1'b0;
        check("w2_dout_delay",  dout_bad,         0);
        check("w2_dout_highs",  dout_ones - d0,   568);
        check("w2_rx_hold",     32'(rx_data),     32'h00A5C3F0);
        check("w2_valid_count", n_valid,          1);

        f0 = n_frame;
        e0 = n_err;
        drive(1'b0, 2500);
        check("latch_frame_once", n_frame - f0, 1);
        check("latch_no_err",     n_err - e0,   0);
        check("latch_armed",      32'(armed),   32'h1);
        send_word(24'h123456);
        check("w3_valid_count", n_valid,      2);
        check("w3_data",        32'(rx_data), 32'h00123456);

        drive(1'b0, 2100);
        e0 = n_err;
        drive(1'b1, 4);
        drive(1'b0, 40);
        check("glitch_err",   n_err - e0, 1);
        check("glitch_armed", 32'(armed), 32'h0);
        send_word(24'hFFFFFF);
        check("glitch_no_valid", n_valid, 2);
        drive(1'b0, 2100);
        send_word(24'h0F0F0F);
        check("glitch_recover_valid", n_valid,      3);
        check("glitch_recover_data",  32'(rx_data), 32'h000F0F0F);

        drive(1'b0, 2100);
        e0 = n_err;
        drive(1'b1, 70);
        drive(1'b0, 40);
        check("long_err",      n_err - e0, 1);
        check("long_no_valid", n_valid,    3);
        drive(1'b0, 2100);
        send_word(24'h5A5A5A);
        check("long_recover_valid", n_valid,      4);
        check("long_recover_data",  32'(rx_data), 32'h005A5A5A);

        drive(1'b0, 2100);
        e0 = n_err;
        f0 = n_frame;
        b0 = n_both;
        send_bits(24'hABCDEF, 10);
        drive(1'b0, 2100);
        check("trunc_same_cycle", n_both - b0,  1);
        check("trunc_err",        n_err - e0,   1);
        check("trunc_frame",      n_frame - f0, 1);
        send_word(24'h3C3C3C);
        check("trunc_next_valid", n_valid,      5);
        check("trunc_next_data",  32'(rx_data), 32'h003C3C3C);

        drive(1'b0, 2100);
        send_bits(24'h777777, 12);
        reset = 1'b1;
        drive(1'b0, 5);
        check("mid_rst_rx_data",    32'(rx_data),    32'h0);
        check("mid_rst_rx_valid",   32'(rx_valid),   32'h0);
        check("mid_rst_frame_done", 32'(frame_done), 32'h0);
        check("mid_rst_bit_error",  32'(bit_error),  32'h0);
        check("mid_rst_armed",      32'(armed),      32'h0);
        check("mid_rst_dout",       32'(dout),       32'h0);
        reset = 1'b0;
        v0 = n_valid;
        send_word(24'h111111);
        check("post_rst_no_valid", n_valid - v0,  0);
        check("post_rst_data",     32'(rx_data),  32'h0);
        check("no_double_pulse",   n_dbl,         0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
